// File: rtl/mem_pipe_be_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_pipe_be_if
// Description : Request/response bus between a bus agent (master) and the
//               mem_pipe_be storage block (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_pipe_be_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // Request channel
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_wr;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [DATA_WIDTH-1:0]   req_wdata;
   logic [DATA_WIDTH/8-1:0] req_be;

   // Response channel (no backpressure)
   logic                    rsp_valid;
   logic                    rsp_wr;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   logic                    rsp_err;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, req_be,
      input  req_ready,
      input  rsp_valid, rsp_wr, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, req_be,
      output req_ready,
      output rsp_valid, rsp_wr, rsp_rdata, rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/mem_pipe_be.sv
`default_nettype none
// ============================================================================
// Module      : mem_pipe_be
// Description : Single-port word memory with valid/ready requests, per-byte
//               write enables, a fixed RD_LATENCY response pipeline, address
//               range checking and a background clear FSM.
//               Optional build macro MEM_PARITY_EN adds per-byte even parity
//               storage, parity checking on reads and the inj_perr input.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_pipe_be #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int RD_LATENCY = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr_start,
   output logic            busy,
`ifdef MEM_PARITY_EN
   input  logic            inj_perr,
`endif
   mem_pipe_be_if.slave    bus
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int IDX_W = $clog2(DEPTH);
   localparam int EXT_W = ADDR_WIDTH + 13;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   typedef struct packed {
      logic                  valid;
      logic                  wr;
      logic                  err;
      logic [DATA_WIDTH-1:0] rdata;
   } rsp_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;

   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
   logic                   mem_we;
   logic [IDX_W-1:0]       mem_widx;
   logic [DATA_WIDTH-1:0]  mem_wdata;
   logic [NB-1:0]          mem_bmask;

   rsp_t                   pipe_q [RD_LATENCY];
   rsp_t                   pipe_d [RD_LATENCY];
   rsp_t                   rsp_in;

   logic                   accept;
   logic                   addr_ok;
   logic [EXT_W-1:0]       addr_ext;
   logic [IDX_W-1:0]       req_idx;
   logic [DATA_WIDTH-1:0]  rd_word;
   logic                   rd_perr;

   // Address is zero-extended so the range check sees every request bit,
   // even when ADDR_WIDTH is narrower than the index.
   assign addr_ext = {13'd0, bus.req_addr};
   assign addr_ok  = (addr_ext < EXT_W'(DEPTH));
   assign req_idx  = addr_ext[IDX_W-1:0];
   assign accept   = bus.req_valid && (state_q == ST_IDLE);
   assign rd_word  = mem_q[req_idx];

   assign busy          = (state_q == ST_CLEAR);
   assign bus.req_ready = (state_q == ST_IDLE);

`ifdef MEM_PARITY_EN
   logic [NB-1:0] par_q [DEPTH];
   logic [NB-1:0] mem_wpar;
   logic [NB-1:0] rd_par;

   assign rd_par = par_q[req_idx];

   // Write parity: even parity per byte, optionally inverted for fault injection.
   always_comb begin
      mem_wpar = '0;
      if (state_q == ST_IDLE) begin
         for (int b = 0; b < NB; b++) begin
            mem_wpar[b] = (^bus.req_wdata[8*b +: 8]) ^ inj_perr;
         end
      end
   end

   // Any byte whose recomputed parity disagrees with the stored bit flags an error.
   always_comb begin
      rd_perr = 1'b0;
      for (int b = 0; b < NB; b++) begin
         if ((^rd_word[8*b +: 8]) != rd_par[b]) begin
            rd_perr = 1'b1;
         end
      end
   end

   // Parity storage follows the data byte enables; clear writes parity 0.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (mem_bmask[b]) begin
               par_q[mem_widx][b] <= mem_wpar[b];
            end
         end
      end
   end
`else
   assign rd_perr = 1'b0;
`endif

   // Clear/idle FSM next-state and the single memory write port.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      mem_we    = 1'b0;
      mem_widx  = idx_q;
      mem_wdata = '0;
      mem_bmask = '0;
      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_bmask = '1;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = ST_IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_IDLE: begin
            idx_d = '0;
            // The request on this edge is still served; clear begins next cycle.
            if (clr_start) begin
               state_d = ST_CLEAR;
            end
            if (accept && bus.req_wr && addr_ok) begin
               mem_we    = 1'b1;
               mem_widx  = req_idx;
               mem_wdata = bus.req_wdata;
               mem_bmask = bus.req_be;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            idx_d   = '0;
         end
      endcase
   end

   // FSM state register; reset restarts the clear from word 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Storage array; contents are defined by the clear FSM, not by reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (mem_bmask[b]) begin
               mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

   // Response entry built at acceptance; fields stay zero when nothing is accepted.
   always_comb begin
      rsp_in = '0;
      if (accept) begin
         rsp_in.valid = 1'b1;
         rsp_in.wr    = bus.req_wr;
         rsp_in.err   = !addr_ok;
         if (!bus.req_wr && addr_ok) begin
            rsp_in.rdata = rd_word;
            rsp_in.err   = rd_perr;
         end
      end
      pipe_d[0] = rsp_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // Response delay line; reset discards anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign bus.rsp_valid = pipe_q[RD_LATENCY-1].valid;
   assign bus.rsp_wr    = pipe_q[RD_LATENCY-1].wr;
   assign bus.rsp_err   = pipe_q[RD_LATENCY-1].err;
   assign bus.rsp_rdata = pipe_q[RD_LATENCY-1].rdata;

endmodule
`default_nettype wire
